escalonador_sensores: RTL and testbench
=======================================

Name: escalonador_sensores

Overview:
- Shares one 16-bit serial response path among N_SENSORES DHT11 sensor controllers.
- Decodes each incoming command word by its address field and pulses the request line of the addressed controller.
- Collects completed responses from the controllers' buffer-ready flags, round-robin, and forwards each one to the transmitter.
- Returns the buffer-used handshake to the controller whose response was sent.

Parameters:
- N_SENSORES, 4: number of attached sensor controllers, range 1..32 (5-bit address field).
- PTR_W, 2: pointer width, equal to max(1, ceil(log2(N_SENSORES))).
- TIMEOUT_LIB, 1000: cycles to wait in LIBERA for a controller to drop its ready flag.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command word available from the receiver.
- cmd_word  in  16  command word: [4:0] sensor address, [11:8] opcode, other bits pass through.
- cmd_ready  out  1  scheduler accepts cmd_word this cycle.
- sinalRequest  out  N_SENSORES  one-cycle request pulse per controller.
- comando  out  16  registered command, broadcast to all controllers.
- bufferPronto  in  N_SENSORES  per-controller response-ready flag.
- info  in  16*N_SENSORES  per-controller response word; controller i uses bits [16i+15:16i].
- bufferUsado  out  N_SENSORES  per-controller response-consumed flag.
- tx_dado  out  16  response word to the transmitter.
- tx_valid  out  1  tx_dado valid.
- tx_ready  in  1  transmitter accepts tx_dado.
- erro_timeout  out  1  sticky flag: a controller did not release its ready flag in time.

Behaviour:
- Reset values: cmd_ready=0, sinalRequest=0, comando=0, bufferUsado=0, tx_dado=0, tx_valid=0, erro_timeout=0, pointer=0, error-pending=0, FSM=OCIOSO.
- cmd_ready is 1 one cycle after reset release, thereafter equal to !erro_pendente.
- Dispatch runs independently of the response FSM.
  - Handshake: cmd_valid && cmd_ready.
  - Valid address (addr < N_SENSORES): on the next edge, comando <= cmd_word and sinalRequest[addr] <= 1 for exactly one cycle.
  - comando is held until the next accepted command.
  - Back-to-back accepted commands give back-to-back pulses.
  - Invalid address (addr >= N_SENSORES): no pulse; comando unchanged. Latch the error word {7'b0, 4'b1110, addr} and set erro_pendente. Code 14 means invalid address.
- Response FSM states: OCIOSO, ENVIA, LIBERA.
- OCIOSO:
  - If erro_pendente: load tx_dado with the error word, mark the source as the internal error source, go to ENVIA. The error word has priority over sensor responses.
  - Else if any bufferPronto bit is set: select the first set index searching from pointer upward with wrap-around, latch that controller's info slice into tx_dado, go to ENVIA.
  - Else stay.
- ENVIA:
  - tx_valid=1; tx_dado is stable.
  - On tx_valid && tx_ready: tx_valid <= 0. If the source is the error source, clear erro_pendente and return to OCIOSO. Otherwise go to LIBERA.
  - Minimum latency from bufferPronto rising to tx_valid is 2 cycles.
- LIBERA:
  - bufferUsado[sel]=1, held until bufferPronto[sel]==0.
  - Then bufferUsado <= 0, pointer <= (sel+1) mod N_SENSORES, go to OCIOSO.
  - If TIMEOUT_LIB cycles elapse first: set erro_timeout, drop bufferUsado, advance pointer, go to OCIOSO anyway.
- At most one bufferUsado bit is set at any time.
- The pointer wraps from N_SENSORES-1 to 0.
- bufferPronto bits of controllers not currently selected are ignored until the next OCIOSO.
- Reset asserted mid-operation forces all reset values immediately. Any latched response or error word is discarded.

Test Plan:
- Reset release, then cmd_word=16'h0302 (addr 2, opcode 3) with cmd_valid=1 for one cycle -> next cycle sinalRequest=4'b0100 for exactly one cycle, comando=16'h0302.
- Invalid address: cmd_word=16'h0107, N_SENSORES=4 -> no sinalRequest; tx_valid=1 with tx_dado=16'h01C7 (addr 7, code 14); cmd_ready=0 until tx_ready handshake completes.
- Single response: bufferPronto[1]=1 with info slice 1 = 16'h3561, tx_ready=1 -> tx_dado=16'h3561 two cycles later. Then bufferUsado[1]=1 until bufferPronto[1] falls, then pointer=2.
- Round-robin: bufferPronto=4'b1011 held, pointer=0 -> service order 0,1,3,0; no index serviced twice while another set bit is waiting.
- Backpressure: tx_ready=0 for 10 cycles -> tx_valid and tx_dado stay stable; bufferUsado stays 0 until the handshake.
- Timeout and reset: bufferPronto[0] stuck at 1 for TIMEOUT_LIB cycles -> erro_timeout=1, bufferUsado=0, pointer=1. Then rst_n=0 mid-ENVIA -> all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/escalonador_sensores.sv
// -----------------------------------------------------------------------------
// escalonador_sensores
// Shares one 16-bit response path among N_SENSORES DHT11 sensor controllers.
// Incoming command words are decoded by their address field, registered onto
// the broadcast bus and announced with a one-cycle request pulse to the
// addressed controller. Completed responses are collected round-robin from the
// controllers' ready flags and forwarded to the transmitter. The consumed
// handshake is then returned to the controller that was serviced.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_word    command from the receiver ([4:0] addr, [11:8] opcode)
//   cmd_ready             command accepted this cycle
//   sinalRequest[N]       one-cycle request pulse per controller
//   comando[16]           registered command, broadcast to all controllers
//   bufferPronto[N]       per-controller response-ready flag
//   info[16*N]            per-controller response words, slice i = [16i+15:16i]
//   bufferUsado[N]        per-controller response-consumed flag
//   tx_dado/tx_valid      response word to the transmitter
//   tx_ready              transmitter accepts tx_dado
//   erro_timeout          sticky: a controller kept its ready flag too long
//
// Response FSM:
//   state  | meaning
//   OCIOSO | idle; pick pending error word or next ready controller
//   ENVIA  | present tx_dado to the transmitter until accepted
//   LIBERA | assert bufferUsado[sel] until the controller drops its ready flag
// -----------------------------------------------------------------------------
module escalonador_sensores #(
    parameter int N_SENSORES  = 4,
    parameter int PTR_W       = 2,
    parameter int TIMEOUT_LIB = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [15:0]             cmd_word,
    output logic                    cmd_ready,
    output logic [N_SENSORES-1:0]   sinalRequest,
    output logic [15:0]             comando,
    input  logic [N_SENSORES-1:0]   bufferPronto,
    input  logic [16*N_SENSORES-1:0] info,
    output logic [N_SENSORES-1:0]   bufferUsado,
    output logic [15:0]             tx_dado,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    erro_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT_LIB + 1);

    typedef enum logic [1:0] {OCIOSO, ENVIA, LIBERA} estado_t;

    estado_t                 r_state, w_state_nxt;
    logic                    r_rdy_en;
    logic [N_SENSORES-1:0]   r_req;
    logic [15:0]             r_comando;
    logic                    r_erro_pendente;
    logic [15:0]             r_erro_word;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_sel;
    logic                    r_src_err;
    logic [15:0]             r_tx_dado;
    logic                    r_tx_valid;
    logic [N_SENSORES-1:0]   r_usado;
    logic                    r_erro_timeout;
    logic [TMR_W-1:0]        r_tmr;

    logic [4:0]              w_addr;
    logic                    w_accept;
    logic                    w_addr_ok;
    logic                    w_found;
    logic [PTR_W-1:0]        w_pick;
    int                      w_dist;
    int                      w_best;
    logic                    w_hs;
    logic                    w_load_err;
    logic                    w_load_rsp;
    logic                    w_clr_err;
    logic                    w_enter_lib;
    logic                    w_release;
    logic                    w_timeout;
    logic [PTR_W-1:0]        w_ptr_nxt;

    assign w_addr    = cmd_word[4:0];
    assign cmd_ready = r_rdy_en && !r_erro_pendente;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_addr_ok = 32'(w_addr) < N_SENSORES;
    assign w_hs      = r_tx_valid && tx_ready;
    assign w_ptr_nxt = (r_sel == PTR_W'(N_SENSORES - 1)) ? '0 : r_sel + 1'b1;

    // Round-robin pick: smallest forward distance from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = N_SENSORES;
        w_dist  = 0;
        for (int i = 0; i < N_SENSORES; i++) begin
            w_dist = i - int'(r_ptr);
            if (w_dist < 0) w_dist = w_dist + N_SENSORES;
            if (bufferPronto[i] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_pick  = PTR_W'(i);
            end
        end
    end

    // Command dispatch, independent of the response FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en        <= 1'b0;
            r_req           <= '0;
            r_comando       <= '0;
            r_erro_word     <= '0;
            r_erro_pendente <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_req    <= '0;
            if (w_accept && w_addr_ok) begin
                r_comando <= cmd_word;
                r_req     <= N_SENSORES'(1) << w_addr;
            end
            // cmd_ready is low while an error is pending, so set and clear
            // can never coincide.
            if (w_accept && !w_addr_ok) begin
                r_erro_word     <= {7'b0, 4'b1110, w_addr};
                r_erro_pendente <= 1'b1;
            end else if (w_clr_err) begin
                r_erro_pendente <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= OCIOSO;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_err  = 1'b0;
        w_load_rsp  = 1'b0;
        w_clr_err   = 1'b0;
        w_enter_lib = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (r_erro_pendente) begin
                    w_load_err  = 1'b1;
                    w_state_nxt = ENVIA;
                end else if (w_found) begin
                    w_load_rsp  = 1'b1;
                    w_state_nxt = ENVIA;
                end
            end
            ENVIA: begin
                if (w_hs) begin
                    if (r_src_err) begin
                        w_clr_err   = 1'b1;
                        w_state_nxt = OCIOSO;
                    end else begin
                        w_enter_lib = 1'b1;
                        w_state_nxt = LIBERA;
                    end
                end
            end
            LIBERA: begin
                if (!bufferPronto[r_sel]) begin
                    w_release   = 1'b1;
                    w_state_nxt = OCIOSO;
                end else if (r_tmr == '0) begin
                    w_release   = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = OCIOSO;
                end
            end
            default: w_state_nxt = OCIOSO;
        endcase
    end

    // Response datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_dado      <= '0;
            r_tx_valid     <= 1'b0;
            r_src_err      <= 1'b0;
            r_sel          <= '0;
            r_ptr          <= '0;
            r_usado        <= '0;
            r_tmr          <= '0;
            r_erro_timeout <= 1'b0;
        end else begin
            if (w_load_err) begin
                r_tx_dado <= r_erro_word;
                r_src_err <= 1'b1;
            end else if (w_load_rsp) begin
                r_tx_dado <= info[{w_pick, 4'b0000} +: 16];
                r_sel     <= w_pick;
                r_src_err <= 1'b0;
            end
            // tx_valid rises on the first ENVIA cycle, giving two cycles
            // from bufferPronto to tx_valid.
            r_tx_valid <= (r_state == ENVIA) && !w_hs;
            if (w_enter_lib) begin
                r_usado <= N_SENSORES'(1) << r_sel;
                r_tmr   <= TMR_W'(TIMEOUT_LIB - 1);
            end else if (r_state == LIBERA && r_tmr != '0) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (w_release) begin
                r_usado <= '0;
                r_ptr   <= w_ptr_nxt;
            end
            if (w_timeout) r_erro_timeout <= 1'b1;
        end
    end

    assign sinalRequest = r_req;
    assign comando      = r_comando;
    assign bufferUsado  = r_usado;
    assign tx_dado      = r_tx_dado;
    assign tx_valid     = r_tx_valid;
    assign erro_timeout = r_erro_timeout;

endmodule

// File: tb/tb_escalonador_sensores.sv
module tb_escalonador_sensores;

    localparam int N  = 4;
    localparam int TO = 1000;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        cmd_ready;
    logic [3:0]  sinalRequest;
    logic [15:0] comando;
    logic [3:0]  bufferPronto;
    logic [63:0] info;
    logic [3:0]  bufferUsado;
    logic [15:0] tx_dado;
    logic        tx_valid;
    logic        tx_ready;
    logic        erro_timeout;

    int n_checks;
    int n_fail;

    logic [15:0] exp_tx[$];
    logic [19:0] exp_req[$];
    logic [1:0]  served[$];

    escalonador_sensores #(.N_SENSORES(N), .PTR_W(2), .TIMEOUT_LIB(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_ready(cmd_ready),
        .sinalRequest(sinalRequest), .comando(comando),
        .bufferPronto(bufferPronto), .info(info), .bufferUsado(bufferUsado),
        .tx_dado(tx_dado), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .erro_timeout(erro_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [15:0] e;
        logic [19:0] r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got %h, none expected", tx_dado);
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_dado", 32'(tx_dado), 32'(e));
                    end
                end
                if (sinalRequest != 4'b0) begin
                    if (exp_req.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL req_unexpected: got %b, none expected", sinalRequest);
                    end else begin
                        r = exp_req.pop_front();
                        chk("sinalRequest", 32'(sinalRequest), 32'(r[19:16]));
                        chk("comando", 32'(comando), 32'(r[15:0]));
                    end
                end
            end
        end
    endtask

    // Controllers: release the ready flag when bufferUsado is seen; with
    // hold set, raise it again once the scheduler has let go.
    task automatic run_service(input int n, input logic [3:0] pattern, input bit hold);
        int         cnt;
        int         budget;
        bit         rel_v;
        logic [1:0] rel;
        logic [1:0] idx;
        cnt = 0; budget = 200; rel_v = 1'b0; rel = 2'd0; idx = 2'd0;
        bufferPronto = pattern;
        while (cnt < n && budget > 0) begin
            tick();
            budget--;
            if (rel_v) begin
                if (hold) bufferPronto[rel] = 1'b1;
                rel_v = 1'b0;
            end
            if (bufferUsado != 4'b0) begin
                chk("usado_onehot", 32'($onehot(bufferUsado)), 32'd1);
                for (int i = 0; i < 4; i++) if (bufferUsado[i]) idx = 2'(i);
                served.push_back(idx);
                cnt++;
                if (cnt == n) bufferPronto = 4'b0;
                else begin
                    bufferPronto[idx] = 1'b0;
                    rel = idx;
                    rel_v = 1'b1;
                end
            end
        end
        chk("service_count", 32'(cnt), 32'(n));
        tick();
        tick();
    endtask

    initial begin
        int         k;
        logic [1:0] s;
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_word = 16'h0;
        bufferPronto = 4'b0;
        info = {16'hC333, 16'h2222, 16'h3561, 16'hA000};
        tx_ready = 1'b1;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_req", 32'(sinalRequest), 0);
        chk("rst_comando", 32'(comando), 0);
        chk("rst_usado", 32'(bufferUsado), 0);
        chk("rst_tx_dado", 32'(tx_dado), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_erro_timeout", 32'(erro_timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_at_release", 32'(cmd_ready), 0);
        tick();
        chk("cmd_ready_after_release", 32'(cmd_ready), 1);

        // Valid command: addr 2, opcode 3
        cmd_word = 16'h0302; cmd_valid = 1'b1;
        exp_req.push_back({4'b0100, 16'h0302});
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("req_one_cycle", 32'(sinalRequest), 0);
        chk("comando_held", 32'(comando), 32'h0302);

        // Back-to-back commands to addr 0 and addr 3
        cmd_word = 16'h0A00; cmd_valid = 1'b1;
        exp_req.push_back({4'b0001, 16'h0A00});
        tick();
        cmd_word = 16'h0B03;
        exp_req.push_back({4'b1000, 16'h0B03});
        tick();
        cmd_valid = 1'b0;
        tick();

        // Invalid address 7 -> error word 0x01C7
        tx_ready = 1'b0;
        cmd_word = 16'h0107; cmd_valid = 1'b1;
        exp_tx.push_back(16'h01C7);
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_err", 32'(cmd_ready), 0);
        k = 0;
        while (!tx_valid && k < 10) begin tick(); k++; end
        chk("err_tx_valid", 32'(tx_valid), 1);
        chk("err_tx_dado", 32'(tx_dado), 32'h01C7);
        chk("err_no_req", 32'(sinalRequest), 0);
        chk("err_comando_kept", 32'(comando), 32'h0B03);
        chk("cmd_ready_wait", 32'(cmd_ready), 0);
        tx_ready = 1'b1;
        k = 0;
        while (!cmd_ready && k < 10) begin tick(); k++; end
        chk("cmd_ready_restored", 32'(cmd_ready), 1);
        chk("err_tx_valid_drop", 32'(tx_valid), 0);

        // Round-robin with 1011 held, pointer 0 -> 0,1,3,0
        exp_tx.push_back(16'hA000);
        exp_tx.push_back(16'h3561);
        exp_tx.push_back(16'hC333);
        exp_tx.push_back(16'hA000);
        served.delete();
        run_service(4, 4'b1011, 1'b1);
        chk("rr_len", 32'(served.size()), 4);
        if (served.size() == 4) begin
            chk("rr_0", 32'(served[0]), 0);
            chk("rr_1", 32'(served[1]), 1);
            chk("rr_2", 32'(served[2]), 3);
            chk("rr_3", 32'(served[3]), 0);
        end

        // Single response from controller 1, two-cycle latency
        exp_tx.push_back(16'h3561);
        bufferPronto = 4'b0010;
        tick();
        chk("lat1_tx_valid", 32'(tx_valid), 0);
        tick();
        chk("lat2_tx_valid", 32'(tx_valid), 1);
        chk("lat2_tx_dado", 32'(tx_dado), 32'h3561);
        served.delete();
        run_service(1, 4'b0010, 1'b0);
        if (served.size() == 1) chk("single_idx", 32'(served[0]), 1);

        // Backpressure, pointer now 2: 1010 -> 3 then 1
        tx_ready = 1'b0;
        exp_tx.push_back(16'hC333);
        exp_tx.push_back(16'h3561);
        bufferPronto = 4'b1010;
        k = 0;
        while (!tx_valid && k < 10) begin tick(); k++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_tx_valid", 32'(tx_valid), 1);
            chk("bp_tx_dado", 32'(tx_dado), 32'hC333);
            chk("bp_usado", 32'(bufferUsado), 0);
            tick();
        end
        tx_ready = 1'b1;
        served.delete();
        run_service(2, 4'b1010, 1'b0);
        if (served.size() == 2) begin
            chk("bp_order_0", 32'(served[0]), 3);
            chk("bp_order_1", 32'(served[1]), 1);
        end

        // Timeout: controller 0 never releases; pointer 2 -> selects 0
        exp_tx.push_back(16'hA000);
        bufferPronto = 4'b0001;
        k = 0;
        while (!bufferUsado[0] && k < 20) begin tick(); k++; end
        chk("to_usado0", 32'(bufferUsado), 32'b0001);
        tx_ready = 1'b0;
        bufferPronto = 4'b0101;
        k = 0;
        while (!erro_timeout && k < TO + 50) begin tick(); k++; end
        chk("to_flag", 32'(erro_timeout), 1);
        chk("to_cycles", 32'(k), 32'(TO));
        chk("to_usado_drop", 32'(bufferUsado), 0);
        // Pointer advanced to 1, so controller 2 beats controller 0
        k = 0;
        while (!tx_valid && k < 10) begin tick(); k++; end
        chk("to_next_valid", 32'(tx_valid), 1);
        chk("to_next_dado", 32'(tx_dado), 32'h2222);
        chk("to_flag_sticky", 32'(erro_timeout), 1);

        // Asynchronous reset mid-ENVIA
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 0);
        chk("arst_tx_dado", 32'(tx_dado), 0);
        chk("arst_erro_timeout", 32'(erro_timeout), 0);
        chk("arst_usado", 32'(bufferUsado), 0);
        chk("arst_cmd_ready", 32'(cmd_ready), 0);
        chk("arst_comando", 32'(comando), 0);
        chk("arst_req", 32'(sinalRequest), 0);
        bufferPronto = 4'b0;
        tx_ready = 1'b1;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_tx_valid", 32'(tx_valid), 0);

        chk("tx_queue_empty", 32'(exp_tx.size()), 0);
        chk("req_queue_empty", 32'(exp_req.size()), 0);
        s = 2'd0;
        if (s != 2'd0) $display("unreachable");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
